// File: rtl/usb_fs_tx.sv
// USB full-speed serial transmitter: SYNC, PID, payload, optional CRC16, NRZI with bit stuffing, EOP.
// Define USB_FS_TX_CRC16_EN to append a CRC16 to data PIDs; otherwise the payload carries it.
module usb_fs_tx (
    input  logic       clk_48mhz,
    input  logic       reset,
    output logic       bit_strobe,
    input  logic       pkt_start,
    input  logic [3:0] tx_pid,
    input  logic       tx_data_avail,
    output logic       tx_data_get,
    input  logic [7:0] tx_data,
    output logic       pkt_end,
    output logic       oe,
    output logic       dp,
    output logic       dn
);

    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StPid,
        StData,
`ifdef USB_FS_TX_CRC16_EN
        StCrc,
`endif
        StEop
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  phase_q, phase_d;
    logic        pend_q, pend_d;
    logic [3:0]  pid_q, pid_d;
    logic [7:0]  shift_q, shift_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  ones_q, ones_d;
    logic        line_q, line_d;
    logic        se0_q, se0_d;
    logic        oe_q, oe_d;
    logic        get_q, get_d;
    logic        end_q, end_d;
`ifdef USB_FS_TX_CRC16_EN
    logic [15:0] crc_q, crc_d;
`endif

    logic        emit;
    logic        emit_bit;
    logic [3:0]  last_cnt;

    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            phase_q <= 2'd0;
            pend_q  <= 1'b0;
            pid_q   <= 4'd0;
            shift_q <= 8'd0;
            cnt_q   <= 4'd0;
            ones_q  <= 3'd0;
            line_q  <= 1'b1;
            se0_q   <= 1'b0;
            oe_q    <= 1'b0;
            get_q   <= 1'b0;
            end_q   <= 1'b0;
`ifdef USB_FS_TX_CRC16_EN
            crc_q   <= 16'hFFFF;
`endif
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            pend_q  <= pend_d;
            pid_q   <= pid_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            ones_q  <= ones_d;
            line_q  <= line_d;
            se0_q   <= se0_d;
            oe_q    <= oe_d;
            get_q   <= get_d;
            end_q   <= end_d;
`ifdef USB_FS_TX_CRC16_EN
            crc_q   <= crc_d;
`endif
        end
    end

    // Each strobe ends the slot on the line and chooses the next one: a stuff bit, the next bit
    // of the current field, the first bit of the next field, or an EOP slot.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q + 2'd1;
        pend_d   = pend_q;
        pid_d    = pid_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        ones_d   = ones_q;
        line_d   = line_q;
        se0_d    = se0_q;
        oe_d     = oe_q;
        get_d    = 1'b0;
        end_d    = 1'b0;
        emit     = 1'b0;
        emit_bit = 1'b0;
`ifdef USB_FS_TX_CRC16_EN
        crc_d    = crc_q;
        last_cnt = (state_q == StCrc) ? 4'd15 : 4'd7;
`else
        last_cnt = 4'd7;
`endif

        if (pkt_start && state_q == StIdle) begin
            pend_d = 1'b1;
            pid_d  = tx_pid;
        end

        if (bit_strobe) begin
            case (state_q)
                StIdle: begin
                    if (pend_q) begin
                        state_d  = StSync;
                        pend_d   = 1'b0;
                        oe_d     = 1'b1;
                        cnt_d    = 4'd0;
                        ones_d   = 3'd0;
                        shift_d  = 8'h80;
                        emit     = 1'b1;
                        emit_bit = 1'b0;
`ifdef USB_FS_TX_CRC16_EN
                        crc_d    = 16'hFFFF;
`endif
                    end
                end
                StEop: begin
                    if (cnt_q == 4'd0) begin
                        cnt_d = 4'd1;
                    end else if (cnt_q == 4'd1) begin
                        cnt_d  = 4'd2;
                        se0_d  = 1'b0;
                        line_d = 1'b1;
                    end else begin
                        state_d = StIdle;
                        cnt_d   = 4'd0;
                        oe_d    = 1'b0;
                        end_d   = 1'b1;
                    end
                end
                default: begin
                    if (ones_q == 3'd6) begin
                        line_d = ~line_q;
                        ones_d = 3'd0;
                    end else if (cnt_q != last_cnt) begin
                        cnt_d = cnt_q + 4'd1;
                        emit  = 1'b1;
`ifdef USB_FS_TX_CRC16_EN
                        if (state_q == StCrc) emit_bit = ~crc_q[4'd15 - cnt_d];
                        else                  emit_bit = shift_q[cnt_d[2:0]];
`else
                        emit_bit = shift_q[cnt_d[2:0]];
`endif
                    end else begin
                        cnt_d = 4'd0;
                        if (state_q == StSync) begin
                            state_d  = StPid;
                            shift_d  = {~pid_q, pid_q};
                            emit     = 1'b1;
                            emit_bit = pid_q[0];
                        end else if (state_q != StEop && tx_data_avail
`ifdef USB_FS_TX_CRC16_EN
                                     && state_q != StCrc
`endif
                                     ) begin
                            state_d  = StData;
                            shift_d  = tx_data;
                            get_d    = 1'b1;
                            emit     = 1'b1;
                            emit_bit = tx_data[0];
`ifdef USB_FS_TX_CRC16_EN
                        end else if (state_q != StCrc && pid_q[1:0] == 2'b11) begin
                            state_d  = StCrc;
                            emit     = 1'b1;
                            emit_bit = ~crc_q[15];
`endif
                        end else begin
                            state_d = StEop;
                            se0_d   = 1'b1;
                        end
                    end
                end
            endcase
        end

        if (emit) begin
            line_d = emit_bit ? line_q : ~line_q;
            ones_d = emit_bit ? ones_q + 3'd1 : 3'd0;
`ifdef USB_FS_TX_CRC16_EN
            if (state_d == StData) begin
                crc_d = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ emit_bit) ? 16'h8005 : 16'h0000);
            end
`endif
        end
    end

    always_comb begin
        bit_strobe  = (phase_q == 2'd0);
        tx_data_get = get_q;
        pkt_end     = end_q;
        oe          = oe_q;
        dp          = oe_q ? (line_q & ~se0_q) : 1'b1;
        dn          = oe_q ? (~line_q & ~se0_q) : 1'b0;
    end

endmodule

// File: tb/tb_usb_fs_tx.sv
// Self-checking bench for usb_fs_tx: line slots compared against a reference built from the
// packet format rules (field bits, CRC16 if USB_FS_TX_CRC16_EN, stuffing, NRZI, EOP).
module tb_usb_fs_tx;

    logic       clk_48mhz = 1'b0;
    logic       reset = 1'b1;
    logic       bit_strobe;
    logic       pkt_start = 1'b0;
    logic [3:0] tx_pid = 4'd0;
    logic       tx_data_avail;
    logic       tx_data_get;
    logic [7:0] tx_data;
    logic       pkt_end;
    logic       oe;
    logic       dp;
    logic       dn;

    usb_fs_tx dut (
        .clk_48mhz     (clk_48mhz),
        .reset         (reset),
        .bit_strobe    (bit_strobe),
        .pkt_start     (pkt_start),
        .tx_pid        (tx_pid),
        .tx_data_avail (tx_data_avail),
        .tx_data_get   (tx_data_get),
        .tx_data       (tx_data),
        .pkt_end       (pkt_end),
        .oe            (oe),
        .dp            (dp),
        .dn            (dn)
    );

    always #5 clk_48mhz = ~clk_48mhz;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk_48mhz) cyc <= cyc + 1;

    // Line monitor: one {dp,dn} sample per bit slot while driving.
    logic [1:0] cap[$];
    int n_end = 0, n_get = 0, get_wide = 0, n_strobe = 0, t_start = 0, t_end = 0;
    logic oe_prev = 1'b0, get_prev = 1'b0;
    always @(negedge clk_48mhz) begin
        if (bit_strobe && oe) cap.push_back({dp, dn});
        if (bit_strobe) n_strobe <= n_strobe + 1;
        if (oe && !oe_prev) t_start <= cyc;
        if (pkt_end) begin
            n_end <= n_end + 1;
            t_end <= cyc;
        end
        if (tx_data_get) begin
            n_get <= n_get + 1;
            if (get_prev) get_wide <= get_wide + 1;
        end
        oe_prev  <= oe;
        get_prev <= tx_data_get;
    end

    // Upstream byte source: advances once per tx_data_get; restarted by bumping gen.
    logic [7:0] pay[16];
    int pay_len = 0, gen = 0, fgen = 0, fidx = 0;
    always @(negedge clk_48mhz) begin
        if (gen != fgen) begin
            fgen <= gen;
            fidx <= 0;
        end else if (tx_data_get) begin
            fidx <= fidx + 1;
        end
    end
    assign tx_data_avail = (fidx < pay_len);
    assign tx_data       = pay[fidx & 15];

    logic [1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic build_exp(input logic [3:0] pid);
        bit         b[$];
        logic [7:0] by;
        int         ones;
        logic       lvl;
`ifdef USB_FS_TX_CRC16_EN
        logic [15:0] r;
        r = 16'hFFFF;
`endif
        exp_q.delete();
        by = 8'h80;
        for (int i = 0; i < 8; i++) b.push_back(by[i]);
        by = {~pid, pid};
        for (int i = 0; i < 8; i++) b.push_back(by[i]);
        for (int k = 0; k < pay_len; k++) begin
            by = pay[k];
            for (int i = 0; i < 8; i++) b.push_back(by[i]);
`ifdef USB_FS_TX_CRC16_EN
            // Reflected CRC16 (0xA001 is 0x8005 bit-reversed), sent complemented LSB first.
            r = r ^ {8'h00, by};
            for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
`endif
        end
`ifdef USB_FS_TX_CRC16_EN
        if (pid[1:0] == 2'b11) for (int i = 0; i < 16; i++) b.push_back(~r[i]);
`endif
        ones = 0;
        lvl  = 1'b1;
        foreach (b[i]) begin
            if (!b[i]) lvl = ~lvl;
            exp_q.push_back(lvl ? 2'b10 : 2'b01);
            ones = b[i] ? ones + 1 : 0;
            if (ones == 6) begin
                lvl = ~lvl;
                exp_q.push_back(lvl ? 2'b10 : 2'b01);
                ones = 0;
            end
        end
        exp_q.push_back(2'b00);
        exp_q.push_back(2'b00);
        exp_q.push_back(2'b10);
    endtask

    task automatic run_pkt(input logic [3:0] pid, input string tag, input bit poke);
        int c0, e0, g0, w0, nbad, nseen;
        bit poked;
        poked = 1'b0;
        build_exp(pid);
        gen = gen + 1;
        repeat (2) @(negedge clk_48mhz);
        c0 = cap.size();
        e0 = n_end;
        g0 = n_get;
        w0 = get_wide;
        pkt_start = 1'b1;
        tx_pid    = pid;
        @(negedge clk_48mhz);
        pkt_start = 1'b0;
        tx_pid    = ~pid;
        for (int i = 0; i < 3000 && n_end == e0; i++) begin
            @(negedge clk_48mhz);
            if (poke && !poked && n_get - g0 == 1) begin
                poked     = 1'b1;
                pkt_start = 1'b1;
                tx_pid    = 4'h2;
                @(negedge clk_48mhz);
                pkt_start = 1'b0;
            end
        end
        repeat (12) @(negedge clk_48mhz);
        chk({tag, " pkt_end count"}, n_end - e0, 1);
        nseen = cap.size() - c0;
        chk({tag, " slot count"}, nseen, exp_q.size());
        nbad = 0;
        for (int i = 0; i < exp_q.size() && i < nseen; i++) begin
            if (cap[c0 + i] !== exp_q[i]) nbad++;
        end
        chk({tag, " bad slots"}, nbad, 0);
        chk({tag, " get pulses"}, n_get - g0, pay_len);
        chk({tag, " wide get"}, get_wide - w0, 0);
        chk({tag, " idle line"}, {oe, dp, dn}, 3'b010);
    endtask

    initial begin
        int s0, e0, g0;
        // Reset state
        repeat (3) @(negedge clk_48mhz);
        chk("reset line", {oe, dp, dn}, 3'b010);
        chk("reset get/end", {tx_data_get, pkt_end}, 2'b00);
        chk("reset phase", bit_strobe, 1'b1);
        reset = 1'b0;
        repeat (4) @(negedge clk_48mhz);
        s0 = n_strobe;
        repeat (40) @(negedge clk_48mhz);
        chk("strobe rate", n_strobe - s0, 10);

        // ACK handshake, including end-of-packet timing
        pay_len = 0;
        run_pkt(4'h2, "ack", 1'b0);
        chk("ack timing", t_end - t_start, 76);

        // Empty DATA0 and DATA1 runs of ones forcing stuffing
        pay_len = 0;
        run_pkt(4'h3, "empty data0", 1'b0);
        pay[0] = 8'hFF; pay[1] = 8'hFF; pay_len = 2;
        run_pkt(4'hB, "stuff ff ff", 1'b0);

        // pkt_start while in DATA must be ignored
        pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03; pay_len = 3;
        run_pkt(4'h3, "poke data0", 1'b1);

        // Reset during the second byte
        gen = gen + 1;
        repeat (2) @(negedge clk_48mhz);
        e0 = n_end;
        g0 = n_get;
        pkt_start = 1'b1;
        tx_pid    = 4'h3;
        @(negedge clk_48mhz);
        pkt_start = 1'b0;
        for (int i = 0; i < 1000 && n_get - g0 < 2; i++) @(negedge clk_48mhz);
        chk("mid reached byte2", n_get - g0, 2);
        repeat (9) @(negedge clk_48mhz);
        #2 reset = 1'b1;
        #1;
        chk("mid reset line", {oe, dp, dn}, 3'b010);
        chk("mid reset get/end", {tx_data_get, pkt_end}, 2'b00);
        repeat (3) @(negedge clk_48mhz);
        reset = 1'b0;
        repeat (200) @(negedge clk_48mhz);
        chk("no resume oe", oe, 1'b0);
        chk("no pkt_end", n_end - e0, 0);
        run_pkt(4'h3, "after reset", 1'b0);

        // Random packets
        for (int p = 0; p < 6; p++) begin
            logic [3:0] rp;
            rp = 4'($urandom_range(0, 15));
            if (p < 3) rp = {rp[3:2], 2'b11};
            pay_len = $urandom_range(0, 4);
            for (int k = 0; k < pay_len; k++) begin
                pay[k] = ($urandom_range(0, 9) < 3) ? 8'hFF : 8'($urandom);
            end
            run_pkt(rp, $sformatf("rand%0d pid=%0h", p, rp), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/usb_fs_tx.md
USB_FS_TX -- requirements
Module: usb_fs_tx

Interface
REQ-001 The block SHALL use one clock, clk_48mhz, and one reset, reset; reset SHALL be asynchronous and active-high.
REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- clk_48mhz  in  1  48 MHz clock
- reset  in  1  asynchronous active-high reset
- bit_strobe  out  1  one-clock pulse per 12 Mb/s bit slot
- pkt_start  in  1  one-clock pulse that starts a packet
- tx_pid  in  4  PID sampled on pkt_start
- tx_data_avail  in  1  a byte is available on tx_data
- tx_data_get  out  1  one-clock pulse; tx_data consumed this clock
- tx_data  in  8  payload byte, LSB sent first
- pkt_end  out  1  one-clock pulse when the packet completes
- oe  out  1  drive enable for dp/dn
- dp  out  1  D+ level
- dn  out  1  D- level
REQ-003 The block SHALL have no parameters.

Function
REQ-004 A free-running 2-bit phase counter SHALL assert bit_strobe when phase==0, giving exactly one pulse every 4 clocks; all line changes occur on the clock after bit_strobe.
REQ-005 The FSM states SHALL be IDLE, SYNC, PID, DATA, CRC, EOP; the CRC state exists only with the macro defined (REQ-015).
REQ-006 In IDLE, pkt_start SHALL latch tx_pid; the next bit_strobe SHALL enter SYNC with oe=1; pkt_start outside IDLE SHALL be ignored.
REQ-007 SYNC SHALL send byte 0x80 LSB first (line KJKJKJKK); PID SHALL then send {~tx_pid, tx_pid} LSB first.
REQ-008 After the PID:
- if tx_data_avail is high, DATA SHALL latch tx_data and pulse tx_data_get for exactly one clock, then shift 8 bits;
- tx_data_avail SHALL be re-checked at each byte boundary;
- when it is low, the FSM SHALL go to CRC for data PIDs (tx_pid[1:0]==2'b11), otherwise to EOP.
REQ-009 NRZI: a 0 bit SHALL toggle J/K and a 1 bit SHALL hold the level; J is dp=1 dn=0, K is dp=0 dn=1.
REQ-010 Bit stuffing:
- after six consecutive 1s, one 0 SHALL be inserted and the shift SHALL stall for that slot;
- the ones counter SHALL reset on every 0 bit and at pkt start;
- SYNC bits SHALL count toward stuffing.
REQ-011 EOP SHALL drive SE0 (dp=dn=0) for two bit slots, then J for one slot, then oe=0 and pulse pkt_end, returning to IDLE.
REQ-012 With oe=0 the outputs SHALL idle at dp=1 dn=0.
REQ-013 A zero-byte packet (tx_data_avail low after PID) SHALL be legal, e.g. handshake or empty DATA0/1.

Reset
REQ-014 On reset assertion, regardless of state:
- the FSM SHALL go to IDLE immediately;
- oe=0, dp=1, dn=0;
- bit_strobe phase=0, tx_data_get=0, pkt_end=0;
- stuff counter=0 and the CRC register=16'hFFFF;
- a packet interrupted mid-transfer SHALL NOT resume after reset releases.

Configuration
REQ-015 With USB_FS_TX_CRC16_EN defined:
- CRC16 (poly 0x8005, init 0xFFFF) SHALL be computed over the DATA bits of data PIDs;
- in the CRC state the block SHALL send the complemented register, bit 15 first, 16 bits, bit-stuffed.
Without the macro, there SHALL be no CRC state, and data PIDs SHALL go directly from DATA to EOP; the upstream supplies CRC bytes as payload.
REQ-016 Tokens SHALL always carry their CRC5 inside the upstream payload bytes.

Verification
REQ-017 Handshake: pkt_start, tx_pid=4'h2 (ACK), tx_data_avail=0 -> the following SHALL be observed:
- line K J K J K J K K, then bits of 0xD2 LSB first NRZI;
- SE0, SE0, J, then oe=0;
- pkt_end pulse after 19 bit slots (76 clocks) from the first SYNC slot.
REQ-018 Empty DATA0 with CRC16 macro: tx_pid=4'h3, no bytes -> PID 0xC3, then 16 zero bits (CRC 0x0000) NRZI-encoded as 16 toggles, then EOP.
REQ-019 Bit stuffing: DATA1 payload 0xFF,0xFF -> a 0 (transition) SHALL be inserted after every sixth consecutive 1, and tx_data_get SHALL pulse exactly twice, one clock each.
REQ-020 Loopback: the output is fed into the team's receiver for a DATA0 {0x01,0x02,0x03} with the macro defined -> the receiver SHALL report valid_packet=1, pid=4'h3, and rx_data 0x01,0x02,0x03.
REQ-021 Reset mid-DATA: reset asserted during byte 2 -> oe=0, dp=1, dn=0 on the same edge; no pkt_end; a new pkt_start after release SHALL send a complete, correct packet.
REQ-022 pkt_start pulsed while in the DATA state -> ignored; the packet completes unchanged with one pkt_end.
